// File: rtl/bridge_sync_fifo_if.sv
// Command-FIFO handshake bundle between the AHB slave front end and the APB master FSM.
// Error-status signals exist only when BRIDGE_FIFO_ERR_EN is defined.
interface bridge_sync_fifo_if #(
  parameter int unsigned DSIZE  = 32,
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned ASIZE  = 4
);
  logic              flush;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DSIZE-1:0]  wr_data;
  logic              wr_write;
  logic              rd_en;
  logic              rd_valid;
  logic [AWIDTH-1:0] rd_addr;
  logic [DSIZE-1:0]  rd_data;
  logic              rd_write;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ASIZE:0]    count;
`ifdef BRIDGE_FIFO_ERR_EN
  logic              err_clr;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_addr, wr_data, wr_write, rd_en, err_clr,
    input  rd_valid, rd_addr, rd_data, rd_write, full, empty,
           almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  flush, wr_en, wr_addr, wr_data, wr_write, rd_en, err_clr,
    output rd_valid, rd_addr, rd_data, rd_write, full, empty,
           almost_full, almost_empty, count, overflow, underflow
  );
`else
  modport master (
    output flush, wr_en, wr_addr, wr_data, wr_write, rd_en,
    input  rd_valid, rd_addr, rd_data, rd_write, full, empty,
           almost_full, almost_empty, count
  );
  modport slave (
    input  flush, wr_en, wr_addr, wr_data, wr_write, rd_en,
    output rd_valid, rd_addr, rd_data, rd_write, full, empty,
           almost_full, almost_empty, count
  );
`endif
endinterface

// File: rtl/bridge_sync_fifo.sv
// Single-clock command FIFO for the AHB-to-APB bridge: registered pop, occupancy count and flags.
// Optional sticky overflow/underflow status is enabled by defining BRIDGE_FIFO_ERR_EN.
module bridge_sync_fifo #(
  parameter int unsigned DSIZE    = 32,
  parameter int unsigned AWIDTH   = 32,
  parameter int unsigned ASIZE    = 4,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic               clk,
  input logic               rst,
  bridge_sync_fifo_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned PW    = ASIZE + 1;

  if (!(AE_LEVEL > 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("bridge_sync_fifo: need 0 < AE_LEVEL < AF_LEVEL <= 2**ASIZE");
  end

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DSIZE-1:0]  data;
    logic              write;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q, count_q;
  logic [PW-1:0]   wptr_n, rptr_n, count_n;
  logic            full_q, empty_q, af_q, ae_q;
  logic            full_n, empty_n, af_n, ae_n;
  logic            rd_valid_q, rd_valid_n;
  entry_t          rd_q, rd_n;
  entry_t          wr_entry_c;
  logic            wr_acc_c, rd_acc_c;

  // Accept decisions use the registered flags, so a full FIFO drops the write and an empty one never bypasses.
  always_comb begin
    wr_acc_c   = bus.wr_en & ~full_q;
    rd_acc_c   = bus.rd_en & ~empty_q;
    wr_entry_c = entry_t'({bus.wr_addr, bus.wr_data, bus.wr_write});
    wptr_n     = wptr_q;
    rptr_n     = rptr_q;
    count_n    = count_q;
    rd_valid_n = 1'b0;
    rd_n       = rd_q;
    if (bus.flush) begin
      wptr_n  = '0;
      rptr_n  = '0;
      count_n = '0;
    end else begin
      if (wr_acc_c) wptr_n = wptr_q + PW'(1);
      if (rd_acc_c) begin
        rptr_n     = rptr_q + PW'(1);
        rd_valid_n = 1'b1;
        rd_n       = mem[rptr_q[ASIZE-1:0]];
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_n = count_q + PW'(1);
        2'b01:   count_n = count_q - PW'(1);
        default: count_n = count_q;
      endcase
    end
    // Flags are precomputed from next-state pointers so they land in the same cycle as count.
    full_n  = (wptr_n[ASIZE-1:0] == rptr_n[ASIZE-1:0]) && (wptr_n[ASIZE] != rptr_n[ASIZE]);
    empty_n = (wptr_n == rptr_n);
    af_n    = (count_n >= PW'(AF_LEVEL));
    ae_n    = (count_n <= PW'(AE_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      wptr_q     <= wptr_n;
      rptr_q     <= rptr_n;
      count_q    <= count_n;
      full_q     <= full_n;
      empty_q    <= empty_n;
      af_q       <= af_n;
      ae_q       <= ae_n;
      rd_valid_q <= rd_valid_n;
      rd_q       <= rd_n;
    end
  end

  // Storage has no reset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && wr_acc_c) mem[wptr_q[ASIZE-1:0]] <= wr_entry_c;
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_addr      = rd_q.addr;
  assign bus.rd_data      = rd_q.data;
  assign bus.rd_write     = rd_q.write;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;

`ifdef BRIDGE_FIFO_ERR_EN
  logic ovf_q, udf_q, ovf_n, udf_n;

  // Sticky error status; a new error wins over err_clr in the same cycle.
  always_comb begin
    ovf_n = ovf_q;
    udf_n = udf_q;
    if (bus.flush) begin
      ovf_n = 1'b0;
      udf_n = 1'b0;
    end else begin
      if (bus.wr_en && full_q)       ovf_n = 1'b1;
      else if (bus.err_clr)          ovf_n = 1'b0;
      if (bus.rd_en && empty_q)      udf_n = 1'b1;
      else if (bus.err_clr)          udf_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_n;
      udf_q <= udf_n;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`endif
endmodule

// File: tb/tb_bridge_sync_fifo.sv
// Scoreboard bench for bridge_sync_fifo: queue-based reference model plus a negedge monitor.
// Compile with BRIDGE_FIFO_ERR_EN defined to also check overflow/underflow.
module tb_bridge_sync_fifo;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        w;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bridge_sync_fifo_if #(.DSIZE(32), .AWIDTH(32), .ASIZE(4)) bus ();

  bridge_sync_fifo #(
    .DSIZE(32), .AWIDTH(32), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   errors = 0;
  int   checks = 0;
  ent_t fifo_q[$];
  ent_t exp_q[$];
  ent_t held = '0;
  ent_t got;
  bit   exp_valid = 1'b0;
  bit   m_ovf = 1'b0;
  bit   m_udf = 1'b0;
  int   n;
  bit   do_pop, do_push;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the FIFO is a plain queue; pops are handed to the monitor via exp_q.
  always @(posedge clk) begin
    if (rst || bus.flush) begin
      fifo_q.delete();
      exp_q.delete();
      exp_valid = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      if (rst) held = '0;
    end else begin
      n       = fifo_q.size();
      do_pop  = bus.rd_en && (n > 0);
      do_push = bus.wr_en && (n < DEPTH);
`ifdef BRIDGE_FIFO_ERR_EN
      if (bus.wr_en && n == DEPTH) m_ovf = 1'b1;
      else if (bus.err_clr)        m_ovf = 1'b0;
      if (bus.rd_en && n == 0)     m_udf = 1'b1;
      else if (bus.err_clr)        m_udf = 1'b0;
`endif
      exp_valid = do_pop;
      if (do_pop) begin
        held = fifo_q.pop_front();
        exp_q.push_back(held);
      end
      if (do_push) fifo_q.push_back(ent_t'({bus.wr_addr, bus.wr_data, bus.wr_write}));
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    n = fifo_q.size();
    check("count",        128'(bus.count),        128'(n));
    check("empty",        128'(bus.empty),        128'(n == 0));
    check("full",         128'(bus.full),         128'(n == DEPTH));
    check("almost_full",  128'(bus.almost_full),  128'(n >= 14));
    check("almost_empty", 128'(bus.almost_empty), 128'(n <= 2));
    check("rd_valid",     128'(bus.rd_valid),     128'(exp_valid));
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected at %0t: rd_valid=1 with no pending model entry", $time);
      end else begin
        got = exp_q.pop_front();
        check("pop_payload", 128'({bus.rd_addr, bus.rd_data, bus.rd_write}), 128'(got));
      end
    end else begin
      exp_q.delete();
      check("hold_payload", 128'({bus.rd_addr, bus.rd_data, bus.rd_write}), 128'(held));
    end
`ifdef BRIDGE_FIFO_ERR_EN
    check("overflow",  128'(bus.overflow),  128'(m_ovf));
    check("underflow", 128'(bus.underflow), 128'(m_udf));
`endif
  end

  task automatic step(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d,
                      input bit w, input bit fl = 1'b0, input bit r = 1'b0, input bit ec = 1'b0);
    bus.wr_en    = we;
    bus.rd_en    = re;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_write = w;
    bus.flush    = fl;
    rst          = r;
`ifdef BRIDGE_FIFO_ERR_EN
    bus.err_clr  = ec;
`else
    if (ec) bus.flush = fl;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_step(input bit we, input bit re);
    step(we, re, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic drain;
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.wr_write = 1'b0;
`ifdef BRIDGE_FIFO_ERR_EN
    bus.err_clr = 1'b0;
`endif
    // Reset and flush
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) rnd_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 32'h1, 32'h1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 3; i++) rnd_step(1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h2, 32'h2, 1'b0, 1'b1);
    idle(2);

    // Fill and drain in order; thresholds are crossed on the way.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      step(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hA000_0000 + iv, iv[0]);
    end
    idle(1);
    drain();
    idle(1);

    // Simultaneous push/pop at count 5, full and empty.
    for (int i = 0; i < 5; i++) rnd_step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) rnd_step(1'b1, 1'b1);
    drain();
    for (int i = 0; i < DEPTH; i++) rnd_step(1'b1, 1'b0);
    rnd_step(1'b1, 1'b1);
    drain();
    rnd_step(1'b1, 1'b1);
    drain();

    // Error status: overflow, underflow, then clear.
    for (int i = 0; i < DEPTH; i++) rnd_step(1'b1, 1'b0);
    rnd_step(1'b1, 1'b0);
    idle(2);
    drain();
    rnd_step(1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    rnd_step(1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Wrap-around around half occupancy.
    for (int i = 0; i < 8; i++) rnd_step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) rnd_step(1'(i % 2 == 0 || $urandom_range(0, 3) == 0),
                                          1'(i % 2 == 1 || $urandom_range(0, 3) == 0));
    drain();

    // Long random traffic with occasional flush and rare reset.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 19) == 0));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
